divider32_fp: RTL and testbench

DIVIDER32_FP -- requirements
Module: divider32_fp

---
 rtl/fp32_pkg.sv | 50 +++++
 rtl/fp32_classify.sv | 37 +++
 rtl/divider32_fp.sv | 259 +++++++++++++++++++++++++
 tb/tb_divider32_fp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fp32_pkg                                             |
// | Description : Shared IEEE-754 single-precision types, constants,   |
// |               operand classes and divider FSM states.              |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package fp32_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] man;
   } fp32_t;

   localparam int          BIAS    = 127;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   // Operand classes; subnormals are flushed into ZERO.
   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } fp_class_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      UNPACK    = 3'd1,
      DIVIDE    = 3'd2,
      NORMALIZE = 3'd3,
      ROUND     = 3'd4,
      DONE      = 3'd5
   } div_state_t;

   // Assemble a single-precision word from its fields.
   function automatic logic [31:0] fp32_pack(input logic       s,
                                             input logic [7:0] e,
                                             input logic [22:0] m);
      fp32_t v;
      v.sign = s;
      v.exp  = e;
      v.man  = m;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fp32_classify                                        |
// | Description : Decodes a single-precision operand into its class,  |
// |               sign, biased exponent and 24-bit mantissa with the   |
// |               hidden bit restored. Subnormals become signed zero.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] i_op,
   output fp_class_t   o_class,
   output logic        o_sign,
   output logic [7:0]  o_exp,
   output logic [23:0] o_man
);

   fp32_t w_op;
   assign w_op = i_op;

   // Field split and class decode; zero exponent covers both zero and subnormal.
   always_comb begin
      o_sign  = w_op.sign;
      o_exp   = w_op.exp;
      o_man   = {1'b1, w_op.man};
      o_class = NORMAL;
      if (w_op.exp == 8'h00) begin
         o_class = ZERO;
         o_man   = 24'd0;
      end else if (w_op.exp == 8'hFF) begin
         o_class = (w_op.man == 23'd0) ? INF : NAN;
      end
   end

endmodule
`default_nettype wire

// File: rtl/divider32_fp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : divider32_fp                                         |
// | Description : Multi-cycle IEEE-754 single-precision divider using  |
// |               26-iteration restoring mantissa division. Fixed      |
// |               latency: 29 cycles normal, 1 cycle special case.     |
// |               Define DIVIDER32_FP_RNE_EN for round-to-nearest-even;|
// |               otherwise the result is truncated (toward zero).     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module divider32_fp
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] quotient_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        nan_o,
   output logic        infinit_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic        div_by_zero_o
);

   localparam logic [4:0] c_LAST_ITER = 5'd25;

   div_state_t         r_state;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic               r_sign;
   logic signed [9:0]  r_exp;
   logic [24:0]        r_rem;
   logic [23:0]        r_div;
   logic [25:0]        r_quo;
   logic [4:0]         r_cnt;
   logic               r_sticky;
   logic [31:0]        r_quotient;
   logic               r_busy;
   logic               r_done;
   logic               r_nan;
   logic               r_inf;
   logic               r_ovf;
   logic               r_unf;
   logic               r_dbz;

   fp_class_t          w_a_class;
   fp_class_t          w_b_class;
   logic               w_a_sign;
   logic               w_b_sign;
   logic [7:0]         w_a_exp;
   logic [7:0]         w_b_exp;
   logic [23:0]        w_a_man;
   logic [23:0]        w_b_man;

   fp32_classify u_class_a (
      .i_op    (r_a),
      .o_class (w_a_class),
      .o_sign  (w_a_sign),
      .o_exp   (w_a_exp),
      .o_man   (w_a_man)
   );

   fp32_classify u_class_b (
      .i_op    (r_b),
      .o_class (w_b_class),
      .o_sign  (w_b_sign),
      .o_exp   (w_b_exp),
      .o_man   (w_b_man)
   );

   logic               w_sign;
   logic signed [9:0]  w_exp_init;

   assign w_sign     = w_a_sign ^ w_b_sign;
   assign w_exp_init = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp})
                     + $signed(10'(BIAS));

   // ---------------- special-case detection ----------------
   logic               w_spec_nan;
   logic               w_spec_inf;
   logic               w_spec_dbz;
   logic               w_spec_zero;
   logic               w_special;
   logic [31:0]        w_spec_q;

   // Priority: NaN beats everything, then inf dividend, then divide-by-zero, then zero results.
   always_comb begin
      w_spec_nan  = (w_a_class == NAN) || (w_b_class == NAN)
                 || ((w_a_class == ZERO) && (w_b_class == ZERO))
                 || ((w_a_class == INF)  && (w_b_class == INF));
      w_spec_inf  = !w_spec_nan && (w_a_class == INF);
      w_spec_dbz  = !w_spec_nan && (w_a_class == NORMAL) && (w_b_class == ZERO);
      w_spec_zero = !w_spec_nan && !w_spec_inf
                 && ((w_b_class == INF) || (w_a_class == ZERO));
      w_special   = w_spec_nan || w_spec_inf || w_spec_dbz || w_spec_zero;
      w_spec_q    = {w_sign, 31'd0};
      if (w_spec_nan) begin
         w_spec_q = QNAN;
      end else if (w_spec_inf || w_spec_dbz) begin
         w_spec_q = w_sign ? NEG_INF : POS_INF;
      end
   end

   // ---------------- restoring division step ----------------
   logic               w_rem_ge;
   logic [24:0]        w_rem_diff;
   logic [24:0]        w_rem_sel;
   logic [24:0]        w_rem_next;

   assign w_rem_ge   = (r_rem >= {1'b0, r_div});
   assign w_rem_diff = r_rem - {1'b0, r_div};
   assign w_rem_sel  = w_rem_ge ? w_rem_diff : r_rem;
   assign w_rem_next = w_rem_sel << 1;

   // ---------------- rounding ----------------
   // After normalization r_quo[25] is the hidden bit, [24:2] the fraction,
   // [1] guard and [0] round; r_sticky covers everything below.
   logic               w_guard;
   logic               w_rs;
   logic               w_round_up;
   logic [24:0]        w_man_sum;
   logic [22:0]        w_man_fin;
   logic signed [9:0]  w_exp_fin;
   logic [31:0]        w_rnd_q;
   logic               w_rnd_ovf;
   logic               w_rnd_unf;

   assign w_guard = r_quo[1];
   assign w_rs    = r_quo[0] | r_sticky;
`ifdef DIVIDER32_FP_RNE_EN
   assign w_round_up = w_guard & (w_rs | r_quo[2]);
`else
   // Truncation: the discarded bits are observed but never add to the result.
   assign w_round_up = w_guard & w_rs & 1'b0;
`endif

   assign w_man_sum = {1'b0, r_quo[25:2]} + {24'd0, w_round_up};
   assign w_man_fin = w_man_sum[24] ? w_man_sum[23:1] : w_man_sum[22:0];
   assign w_exp_fin = r_exp + $signed({9'd0, w_man_sum[24]});

   // Range check of the final exponent selects normal, overflow or underflow result.
   always_comb begin
      w_rnd_q   = fp32_pack(r_sign, w_exp_fin[7:0], w_man_fin);
      w_rnd_ovf = 1'b0;
      w_rnd_unf = 1'b0;
      if (w_exp_fin >= 10'sd255) begin
         w_rnd_q   = r_sign ? NEG_INF : POS_INF;
         w_rnd_ovf = 1'b1;
      end else if (w_exp_fin <= 10'sd0) begin
         w_rnd_q   = {r_sign, 31'd0};
         w_rnd_unf = 1'b1;
      end
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_sign     <= 1'b0;
         r_exp      <= 10'sd0;
         r_rem      <= 25'd0;
         r_div      <= 24'd0;
         r_quo      <= 26'd0;
         r_cnt      <= 5'd0;
         r_sticky   <= 1'b0;
         r_quotient <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_nan      <= 1'b0;
         r_inf      <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_dbz      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_a     <= a_i;
                  r_b     <= b_i;
                  r_busy  <= 1'b1;
                  r_state <= UNPACK;
               end
            end
            UNPACK: begin
               r_sign <= w_sign;
               r_exp  <= w_exp_init;
               r_rem  <= {1'b0, w_a_man};
               r_div  <= w_b_man;
               r_quo  <= 26'd0;
               r_cnt  <= 5'd0;
               if (w_special) begin
                  r_quotient <= w_spec_q;
                  r_nan      <= w_spec_nan;
                  r_inf      <= w_spec_inf | w_spec_dbz;
                  r_ovf      <= 1'b0;
                  r_unf      <= 1'b0;
                  r_dbz      <= w_spec_dbz;
                  r_done     <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_state <= DIVIDE;
               end
            end
            DIVIDE: begin
               r_quo <= {r_quo[24:0], w_rem_ge};
               r_rem <= w_rem_next;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == c_LAST_ITER) begin
                  r_state <= NORMALIZE;
               end
            end
            NORMALIZE: begin
               r_sticky <= (r_rem != 25'd0);
               if (!r_quo[25]) begin
                  r_quo <= {r_quo[24:0], 1'b0};
                  r_exp <= r_exp - 10'sd1;
               end
               r_state <= ROUND;
            end
            ROUND: begin
               r_quotient <= w_rnd_q;
               r_nan      <= 1'b0;
               r_inf      <= w_rnd_ovf;
               r_ovf      <= w_rnd_ovf;
               r_unf      <= w_rnd_unf;
               r_dbz      <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign quotient_o    = r_quotient;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign nan_o         = r_nan;
   assign infinit_o     = r_inf;
   assign overflow_o    = r_ovf;
   assign underflow_o   = r_unf;
   assign div_by_zero_o = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider32_fp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_divider32_fp                                      |
// | Description : Directed self-checking bench for divider32_fp.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_divider32_fp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [31:0] quotient_o;
   logic        busy_o;
   logic        done_o;
   logic        nan_o;
   logic        infinit_o;
   logic        overflow_o;
   logic        underflow_o;
   logic        div_by_zero_o;
   logic [4:0]  w_flags;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef DIVIDER32_FP_RNE_EN
   localparam logic [31:0] c_THIRD = 32'h3EAA_AAAB;
`else
   localparam logic [31:0] c_THIRD = 32'h3EAA_AAAA;
`endif

   // flags as {nan, inf, overflow, underflow, div_by_zero}
   assign w_flags = {nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o};

   always #5 clk = ~clk;

   divider32_fp dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .a_i           (a_i),
      .b_i           (b_i),
      .quotient_o    (quotient_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .nan_o         (nan_o),
      .infinit_o     (infinit_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o),
      .div_by_zero_o (div_by_zero_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and watch a fixed 36-cycle window after the accept edge.
   // inj > 0 pulses start_i with other operands at accept+inj.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                         output int lat, output int ndone, output logic busy1);
      lat   = 0;
      ndone = 0;
      busy1 = 1'b0;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      a_i     = 32'hDEAD_BEEF;
      b_i     = 32'h3F80_0000;
      for (int k = 1; k <= 36; k++) begin
         if (k == inj) begin
            start_i = 1'b1;
            a_i     = 32'h3F80_0000;
            b_i     = 32'h4040_0000;
         end
         @(posedge clk);
         #1;
         start_i = 1'b0;
         if (k == 1) busy1 = busy_o;
         if (done_o) begin
            ndone++;
            if (lat == 0) lat = k;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [4:0] exp_f,
                        input int exp_lat, input int inj);
      int   lat;
      int   ndone;
      logic busy1;
      run_op(a, b, inj, lat, ndone, busy1);
      check({tag, "_q"},     quotient_o, exp_q);
      check({tag, "_flags"}, {27'd0, w_flags}, {27'd0, exp_f});
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_ndone"}, ndone, 32'd1);
      check({tag, "_busy1"}, {31'd0, busy1}, 32'd1);
      check({tag, "_idle"},  {30'd0, busy_o, done_o}, 32'd0);
   endtask

   initial begin
      int ndone;
      rst_n   = 1'b0;
      start_i = 1'b0;
      a_i     = 32'd0;
      b_i     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q",     quotient_o, 32'd0);
      check("rst_flags", {27'd0, w_flags}, 32'd0);
      check("rst_ctl",   {30'd0, busy_o, done_o}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("div25_10",  32'h41C8_0000, 32'h4120_0000, 32'h4020_0000, 5'b00000, 29, 0);
      do_op("neg3_2",    32'hC040_0000, 32'h4000_0000, 32'hBFC0_0000, 5'b00000, 29, 0);
      do_op("one_third", 32'h3F80_0000, 32'h4040_0000, c_THIRD,       5'b00000, 29, 0);
      do_op("one_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01001, 1,  0);
      do_op("negone_z",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01001, 1,  0);
      do_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000, 1,  0);
      do_op("inf_two",   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 5'b01000, 1,  0);
      do_op("two_inf",   32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 5'b00000, 1,  0);
      do_op("subn_one",  32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 5'b00000, 1,  0);
      do_op("underflow", 32'h0080_0000, 32'h7F7F_FFFF, 32'h0000_0000, 5'b00010, 29, 0);
      do_op("overflow",  32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000, 5'b01100, 29, 0);
      do_op("ign_start", 32'h41C8_0000, 32'h4120_0000, 32'h4020_0000, 5'b00000, 29, 5);

      // Abort at accept+10; held result from the previous request must vanish.
      a_i     = 32'h7F7F_FFFF;
      b_i     = 32'h0080_0000;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_q",     quotient_o, 32'd0);
      check("abort_flags", {27'd0, w_flags}, 32'd0);
      check("abort_ctl",   {30'd0, busy_o, done_o}, 32'd0);
      ndone = 0;
      for (int k = 1; k <= 36; k++) begin
         if (k == 3) rst_n = 1'b1;
         @(posedge clk);
         #1;
         if (done_o) ndone++;
      end
      check("abort_ndone", ndone, 32'd0);
      check("abort_busy",  {31'd0, busy_o}, 32'd0);

      do_op("after_rst", 32'h41C8_0000, 32'h4120_0000, 32'h4020_0000, 5'b00000, 29, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
